// File: rtl/relm_ps2_rx.sv
// relm_ps2_rx: PS/2 device-to-host receiver feeding a CPU pop port.
// Both pins are synchronised and glitch-filtered. Each 11-bit frame is
// sampled on the falling edge of the filtered clock and then checked.
// Good bytes go into a show-ahead register FIFO. Sticky overflow and
// frame-error flags are reported alongside the head byte.
//
// Pop handshake: pop_d[WD] is a request strobe. It is accepted in the same
// cycle when pop_q[WD] (empty/retry) is 0; the CPU takes pop_q[7:0] in that
// cycle and the head advances on the following clk edge. A strobe while
// pop_q[WD]=1 is a no-op apart from the optional flag clear on pop_d[WD-1].
`timescale 1ns/1ps
module relm_ps2_rx #(
    parameter int WD      = 32,
    parameter int WAD     = 2,
    parameter int NFILT   = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ps2_clk_in,
    input  logic          ps2_dat_in,
    input  logic [WD:0]   pop_d,
    output logic [WD:0]   pop_q,
    output logic          frame_err_out
);

    localparam int DEPTH = 2 ** WAD;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [WAD:0]   CNT_ONE  = 1;
    localparam logic [WAD:0]   CNT_FULL = (WAD + 1)'(DEPTH);
    localparam logic [WAD-1:0] PTR_ONE  = 1;
    localparam logic [TW-1:0]  TMO_ONE  = 1;
    localparam logic [TW-1:0]  TMO_MAX  = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]       clk_sync, dat_sync;
    logic [NFILT-1:0] clk_sr, dat_sr;
    logic             clk_filt, dat_filt, clk_filt_d;
    logic             sample;

    state_t           state, state_nx;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_q;
    logic             par_q;
    logic [TW-1:0]    tmo_cnt;
    logic             tmo_hit;
    logic             frame_ok, frame_bad, tmo_abort;

    logic [7:0]       mem [DEPTH];
    logic [WAD-1:0]   wr_ptr, rd_ptr;
    logic [WAD:0]     cnt;
    logic             empty, full;
    logic             do_push, do_pop, ovf_set, err_set, flag_clr;
    logic             ovf_q, err_q;
    logic             unused_pop_bits;

    assign unused_pop_bits = ^pop_d[WD-2:0];

    // Two-flop synchronisers for both raw pins; idle level is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
        end
    end

    // Majority-free filter: a line only flips once NFILT samples agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sr     <= '1;
            dat_sr     <= '1;
            clk_filt   <= 1'b1;
            dat_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
        end else begin
            clk_sr     <= {clk_sr[NFILT-2:0], clk_sync[1]};
            dat_sr     <= {dat_sr[NFILT-2:0], dat_sync[1]};
            if (&clk_sr)       clk_filt <= 1'b1;
            else if (~|clk_sr) clk_filt <= 1'b0;
            if (&dat_sr)       dat_filt <= 1'b1;
            else if (~|dat_sr) dat_filt <= 1'b0;
            clk_filt_d <= clk_filt;
        end
    end

    assign sample  = clk_filt_d & ~clk_filt;
    assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_MAX);

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and frame verdict; a timeout overrides any sample event.
    always_comb begin
        state_nx  = state;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        tmo_abort = 1'b0;
        if (tmo_hit) begin
            state_nx  = IDLE;
            tmo_abort = 1'b1;
        end else if (sample) begin
            case (state)
                IDLE:   if (!dat_filt) state_nx = DATA;
                DATA:   if (bit_cnt == 3'd7) state_nx = PARITY;
                PARITY: state_nx = STOP;
                STOP: begin
                    if (dat_filt && (^{shift_q, par_q})) frame_ok  = 1'b1;
                    else                                 frame_bad = 1'b1;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Deserialiser datapath and inactivity counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 3'd0;
            shift_q <= 8'hFF;
            par_q   <= 1'b1;
            tmo_cnt <= '0;
        end else begin
            if (sample || tmo_hit || state == IDLE) tmo_cnt <= '0;
            else                                    tmo_cnt <= tmo_cnt + TMO_ONE;
            if (sample) begin
                case (state)
                    IDLE:   bit_cnt <= 3'd0;
                    DATA: begin
                        shift_q <= {dat_filt, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY: par_q <= dat_filt;
                    default: ;
                endcase
            end
        end
    end

    assign empty    = (cnt == '0);
    assign full     = (cnt == CNT_FULL);
    assign do_pop   = pop_d[WD] & ~empty;
    assign do_push  = frame_ok & (~full | do_pop);
    assign ovf_set  = frame_ok & full & ~do_pop;
    assign err_set  = frame_bad | tmo_abort;
    assign flag_clr = pop_d[WD] & pop_d[WD-1];

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= shift_q;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: ;
            endcase
        end
    end

    // Sticky flags (set beats clear) and the per-frame error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q         <= 1'b0;
            err_q         <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            ovf_q         <= ovf_set | (ovf_q & ~flag_clr);
            err_q         <= err_set | (err_q & ~flag_clr);
            frame_err_out <= err_set;
        end
    end

    // Show-ahead read port.
    always_comb begin
        pop_q       = '0;
        pop_q[WD]   = empty;
        pop_q[9]    = ovf_q;
        pop_q[8]    = err_q;
        pop_q[7:0]  = empty ? 8'h00 : mem[rd_ptr];
    end

endmodule
